grad_product_window: RTL and testbench
======================================

GRAD_PRODUCT_WINDOW -- requirements
Module: grad_product_window

Interface
REQ-001 Parameter WIN, default 5: sliding-window length in samples; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ix_in/iy_in carry a sample this cycle.
REQ-005 ix_in  input  16  signed horizontal gradient.
REQ-006 iy_in  input  16  signed vertical gradient, the output of the Iy row-kernel stage.
REQ-007 line_start  input  1  start of a new row; clears window history.
REQ-008 out_valid  output  1  sxx/syy/sxy hold a complete window sum this cycle.
REQ-009 sxx  output  32  signed sum of Ix*Ix over the last WIN samples.
REQ-010 syy  output  32  signed sum of Iy*Iy over the last WIN samples.
REQ-011 sxy  output  32  signed sum of Ix*Iy over the last WIN samples.

Function
REQ-012 Stage 1 SHALL register the full-precision 32-bit signed products ix*ix, iy*iy and ix*iy on in_valid.
REQ-013 Stage 2 SHALL keep a WIN-deep history of each product and a 36-bit signed running sum: sum <= sum + newest - oldest.
REQ-014 The oldest term SHALL be 0 while fewer than WIN samples have entered since the last clear.
REQ-015 Latency SHALL be exactly 2 cycles: a sample on in_valid at cycle N contributes to outputs valid at cycle N+2.
REQ-016 When in_valid is low, the pipeline SHALL stall: no history shift, no sum change, no out_valid pulse for that slot.
REQ-017 The fill control SHALL use states EMPTY (count 0), FILL (count 1..WIN-1) and FULL (count >= WIN), advancing one count per accepted sample and saturating in FULL.
REQ-018 out_valid SHALL pulse for one cycle per accepted sample only if that sample brought the state to FULL or arrived while FULL.
REQ-019 A line_start without in_valid SHALL zero the history, sums and count, set EMPTY, and make the next sample the first of the window.
REQ-020 A line_start together with in_valid SHALL clear the history, load that sample as the first entry, and set the count to 1.
REQ-021 Samples in flight in stage 1 when line_start arrives SHALL be discarded and SHALL NOT produce out_valid.
REQ-022 When out_valid is low, sxx, syy and sxy SHALL hold their last value.
REQ-023 The output width rule SHALL be set by the configuration macro (REQ-027/REQ-028).

Reset
REQ-024 On reset high at a clock edge: out_valid=0; sxx=syy=sxy=0; all product, history and sum registers=0; state EMPTY.
REQ-025 A reset asserted mid-window SHALL discard all partial sums; the first out_valid after release requires WIN new samples.
REQ-026 reset SHALL take priority over line_start and in_valid in the same cycle.

Configuration
REQ-027 With macro GPW_SAT_EN defined, each output SHALL be the 36-bit sum clamped to the range [-2147483648, 2147483647].
REQ-028 Without GPW_SAT_EN, each output SHALL be the low 32 bits of the 36-bit sum, wrapping two's-complement; no clamp logic is instantiated.

Verification
REQ-029 Reset: hold reset 3 cycles with random inputs -> out_valid=0 and sxx=syy=sxy=0 throughout and 1 cycle after release.
REQ-030 Fill, WIN=5: line_start, then Ix=1..5 with Iy=2 on consecutive cycles -> first out_valid 2 cycles after Ix=5, with sxx=55, syy=20, sxy=30; next sample Ix=6, Iy=2 -> sxx=90, syy=20, sxy=40.
REQ-031 Stall: same stimulus as REQ-030 with in_valid low for 3 cycles after the 3rd sample -> identical output values, first out_valid delayed exactly 3 cycles.
REQ-032 Row restart: in FULL, line_start with in_valid on Ix=Iy=1 -> no out_valid until 4 further samples; first sum excludes all pre-restart data.
REQ-033 Saturation, WIN=5: five samples Ix=Iy=-32768 -> with GPW_SAT_EN, sxx=syy=sxy=2147483647; without it, sxx=syy=sxy=1073741824.
REQ-034 Mid-operation reset: reset during FILL with 3 samples accepted, then 5 samples Ix=1, Iy=0 -> single valid window with sxx=5, syy=0, sxy=0.

Source files
------------

// File: rtl/grad_product_window.sv
// Sliding-window sums of gradient products (Ix*Ix, Iy*Iy, Ix*Iy) over the last WIN samples of a row.
// Define GPW_SAT_EN to clamp outputs to the signed 32-bit range; otherwise outputs wrap.
module grad_product_window #(
  parameter int WIN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] ix_in,
  input  logic signed [15:0] iy_in,
  input  logic               line_start,
  output logic               out_valid,
  output logic signed [31:0] sxx,
  output logic signed [31:0] syy,
  output logic signed [31:0] sxy
);

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_CNT = CW'(WIN);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} fill_state_t;

  logic               p_valid;
  logic signed [31:0] p_xx, p_yy, p_xy;
  logic signed [31:0] ix_ext, iy_ext;

  logic signed [31:0] h_xx [WIN];
  logic signed [31:0] h_yy [WIN];
  logic signed [31:0] h_xy [WIN];
  logic signed [35:0] s_xx, s_yy, s_xy;
  logic signed [35:0] s_xx_d, s_yy_d, s_xy_d;
  logic signed [31:0] old_xx, old_yy, old_xy;
  logic signed [31:0] o_xx_d, o_yy_d, o_xy_d;

  fill_state_t        state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               accept;
  logic               load_out;

  assign ix_ext = 32'(ix_in);
  assign iy_ext = 32'(iy_in);

  // Stage 1: register full-precision products; the valid flag marks the slot for stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_xx    <= '0;
      p_yy    <= '0;
      p_xy    <= '0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_xx <= ix_ext * ix_ext;
        p_yy <= iy_ext * iy_ext;
        p_xy <= ix_ext * iy_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A line_start kills whatever sits in stage 1, so it also blocks acceptance this cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    accept   = p_valid && !line_start;
    load_out = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          count_d = CW'(1);
          state_d = (WIN_CNT == CW'(1)) ? FULL : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_d == WIN_CNT) state_d = FULL;
        end
      end
      FULL: begin
        count_d = WIN_CNT;
      end
      default: begin
        state_d = EMPTY;
        count_d = '0;
      end
    endcase
    if (line_start) begin
      state_d = EMPTY;
      count_d = '0;
    end
    load_out = accept && (state_d == FULL);
  end

`ifdef GPW_SAT_EN
  function automatic logic signed [31:0] clamp36(input logic signed [35:0] v);
    if (v[35:31] == 5'b00000 || v[35:31] == 5'b11111) clamp36 = v[31:0];
    else if (v[35])                                   clamp36 = 32'h8000_0000;
    else                                              clamp36 = 32'h7FFF_FFFF;
  endfunction
`endif

  // Until the window is full the departing term does not exist yet.
  always_comb begin
    old_xx = '0;
    old_yy = '0;
    old_xy = '0;
    if (state_q == FULL) begin
      old_xx = h_xx[WIN-1];
      old_yy = h_yy[WIN-1];
      old_xy = h_xy[WIN-1];
    end
    s_xx_d = s_xx + 36'(p_xx) - 36'(old_xx);
    s_yy_d = s_yy + 36'(p_yy) - 36'(old_yy);
    s_xy_d = s_xy + 36'(p_xy) - 36'(old_xy);
`ifdef GPW_SAT_EN
    o_xx_d = clamp36(s_xx_d);
    o_yy_d = clamp36(s_yy_d);
    o_xy_d = clamp36(s_xy_d);
`else
    o_xx_d = s_xx_d[31:0];
    o_yy_d = s_yy_d[31:0];
    o_xy_d = s_xy_d[31:0];
`endif
  end

  // Stage 2: history shift, running sums, and output registers that hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) begin
        h_xx[i] <= '0;
        h_yy[i] <= '0;
        h_xy[i] <= '0;
      end
      s_xx      <= '0;
      s_yy      <= '0;
      s_xy      <= '0;
      out_valid <= 1'b0;
      sxx       <= '0;
      syy       <= '0;
      sxy       <= '0;
    end else if (line_start) begin
      for (int i = 0; i < WIN; i++) begin
        h_xx[i] <= '0;
        h_yy[i] <= '0;
        h_xy[i] <= '0;
      end
      s_xx      <= '0;
      s_yy      <= '0;
      s_xy      <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      h_xx[0] <= p_xx;
      h_yy[0] <= p_yy;
      h_xy[0] <= p_xy;
      for (int i = 1; i < WIN; i++) begin
        h_xx[i] <= h_xx[i-1];
        h_yy[i] <= h_yy[i-1];
        h_xy[i] <= h_xy[i-1];
      end
      s_xx      <= s_xx_d;
      s_yy      <= s_yy_d;
      s_xy      <= s_xy_d;
      out_valid <= load_out;
      if (load_out) begin
        sxx <= o_xx_d;
        syy <= o_yy_d;
        sxy <= o_xy_d;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grad_product_window.sv
// Randomized and directed bench for grad_product_window against a queue-based window model.
// Honours GPW_SAT_EN the same way the design does.
module tb_grad_product_window;

  localparam int WIN = 5;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] ix_in = '0;
  logic signed [15:0] iy_in = '0;
  logic               line_start = 1'b0;
  logic               out_valid;
  logic signed [31:0] sxx, syy, sxy;

  int checks = 0;
  int errors = 0;

  grad_product_window #(.WIN(WIN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ix_in(ix_in), .iy_in(iy_in),
    .line_start(line_start), .out_valid(out_valid), .sxx(sxx), .syy(syy), .sxy(sxy)
  );

  always #5 clk = ~clk;

  // Reference: the window is simply the list of accepted products since the last clear.
  longint q_xx[$], q_yy[$], q_xy[$];
  bit     pend_v = 1'b0;
  longint pend_xx, pend_yy, pend_xy;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_sxx = '0, exp_syy = '0, exp_sxy = '0;

  function automatic logic [31:0] model_out(input longint s);
`ifdef GPW_SAT_EN
    if (s > MAX32) return 32'h7FFF_FFFF;
    if (s < MIN32) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  task automatic model_step();
    longint a, b, c;
    if (reset) begin
      q_xx.delete(); q_yy.delete(); q_xy.delete();
      pend_v = 1'b0;
      exp_valid = 1'b0;
      exp_sxx = '0; exp_syy = '0; exp_sxy = '0;
    end else begin
      exp_valid = 1'b0;
      if (line_start) begin
        q_xx.delete(); q_yy.delete(); q_xy.delete();
      end else if (pend_v) begin
        q_xx.push_back(pend_xx); q_yy.push_back(pend_yy); q_xy.push_back(pend_xy);
        if (q_xx.size() > WIN) begin
          void'(q_xx.pop_front()); void'(q_yy.pop_front()); void'(q_xy.pop_front());
        end
        if (q_xx.size() == WIN) begin
          a = 0; b = 0; c = 0;
          for (int i = 0; i < WIN; i++) begin
            a += q_xx[i]; b += q_yy[i]; c += q_xy[i];
          end
          exp_valid = 1'b1;
          exp_sxx = model_out(a); exp_syy = model_out(b); exp_sxy = model_out(c);
        end
      end
      pend_v = in_valid;
      if (in_valid) begin
        pend_xx = longint'(ix_in) * longint'(ix_in);
        pend_yy = longint'(iy_in) * longint'(iy_in);
        pend_xy = longint'(ix_in) * longint'(iy_in);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic ls, input logic v,
                       input logic signed [15:0] ix, input logic signed [15:0] iy);
    reset = rst; line_start = ls; in_valid = v; ix_in = ix; iy_in = iy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      drive(k < 3, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", k, out_valid);
      end
      checks++;
      if ({sxx, syy, sxy} !== 96'h0) begin
        errors++; $display("[TB] FAIL reset_sums[%0d]: got %0d %0d %0d expected 0 0 0", k, sxx, syy, sxy);
      end
    end
  endtask

  task automatic test_fill();
    drive(0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 1, 16'(k), 16'sd2);
      checks++;
      if (out_valid !== (k == 6)) begin
        errors++; $display("[TB] FAIL fill_valid[%0d]: got %b expected %b", k, out_valid, (k == 6));
      end
    end
    checks++;
    if (sxx !== 32'sd55 || syy !== 32'sd20 || sxy !== 32'sd30) begin
      errors++; $display("[TB] FAIL fill_first: got %0d %0d %0d expected 55 20 30", sxx, syy, sxy);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || sxx !== 32'sd90 || syy !== 32'sd20 || sxy !== 32'sd40) begin
      errors++; $display("[TB] FAIL fill_slide: got v=%b %0d %0d %0d expected v=1 90 20 40", out_valid, sxx, syy, sxy);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || sxx !== 32'sd90 || syy !== 32'sd20 || sxy !== 32'sd40) begin
      errors++; $display("[TB] FAIL fill_hold: got v=%b %0d %0d %0d expected v=0 90 20 40", out_valid, sxx, syy, sxy);
    end
  endtask

  task automatic test_stall();
    int seq [10] = '{1, 2, 3, 0, 0, 0, 4, 5, 0, 0};
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, seq[i] != 0, 16'(seq[i]), 16'sd2);
      checks++;
      if (out_valid !== (i == 8)) begin
        errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected %b", i, out_valid, (i == 8));
      end
      if (i >= 8) begin
        checks++;
        if (sxx !== 32'sd55 || syy !== 32'sd20 || sxy !== 32'sd30) begin
          errors++; $display("[TB] FAIL stall_sums[%0d]: got %0d %0d %0d expected 55 20 30", i, sxx, syy, sxy);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic signed [15:0] ax [4];
    logic signed [15:0] ay [4];
    longint exx, eyy, exy;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 16'($urandom), 16'($urandom));
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_full: got %b expected 1", out_valid);
    end
    exx = 1; eyy = 1; exy = 1;
    for (int i = 0; i < 4; i++) begin
      ax[i] = 16'($urandom); ay[i] = 16'($urandom);
      exx += longint'(ax[i]) * ax[i]; eyy += longint'(ay[i]) * ay[i]; exy += longint'(ax[i]) * ay[i];
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(0, 1, 1, 16'sd1, 16'sd1);
      else if (i <= 4) drive(0, 0, 1, ax[i-1], ay[i-1]);
      else             drive(0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== (i == 5)) begin
        errors++; $display("[TB] FAIL restart_valid[%0d]: got %b expected %b", i, out_valid, (i == 5));
      end
      if (i == 5) begin
        checks++;
        if (sxx !== model_out(exx) || syy !== model_out(eyy) || sxy !== model_out(exy)) begin
          errors++; $display("[TB] FAIL restart_sums: got %0d %0d %0d expected %0d %0d %0d",
                             sxx, syy, sxy, $signed(model_out(exx)), $signed(model_out(eyy)), $signed(model_out(exy)));
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] want;
`ifdef GPW_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h4000_0000;
`endif
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(0, 0, 1, 16'sh8000, 16'sh8000);
      else       drive(0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== (i == 5)) begin
        errors++; $display("[TB] FAIL sat_valid[%0d]: got %b expected %b", i, out_valid, (i == 5));
      end
    end
    checks++;
    if (sxx !== want || syy !== want || sxy !== want) begin
      errors++; $display("[TB] FAIL sat_sums: got %0d %0d %0d expected %0d", sxx, syy, sxy, $signed(want));
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'($urandom), 16'($urandom));
    drive(1, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || {sxx, syy, sxy} !== 96'h0) begin
      errors++; $display("[TB] FAIL midrst_clear: got v=%b %0d %0d %0d expected v=0 0 0 0", out_valid, sxx, syy, sxy);
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 5) drive(0, 0, 1, 16'sd1, 16'sd0);
      else       drive(0, 0, 0, 0, 0);
      if (out_valid === 1'b1) begin
        pulses++;
        checks++;
        if (i != 5 || sxx !== 32'sd5 || syy !== 32'sd0 || sxy !== 32'sd0) begin
          errors++; $display("[TB] FAIL midrst_window: got slot %0d %0d %0d %0d expected slot 5 5 0 0", i, sxx, syy, sxy);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("[TB] FAIL midrst_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] ix, iy;
    for (int n = 0; n < 600; n++) begin
      ix = ($urandom_range(0, 9) == 0) ? 16'sh8000 : 16'($urandom);
      iy = ($urandom_range(0, 9) == 0) ? 16'sh8000 : 16'($urandom);
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, ix, iy);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, exp_valid);
      end
      checks++;
      if (sxx !== exp_sxx || syy !== exp_syy || sxy !== exp_sxy) begin
        errors++; $display("[TB] FAIL rand_sums[%0d]: got %0d %0d %0d expected %0d %0d %0d", n,
                           sxx, syy, sxy, $signed(exp_sxx), $signed(exp_syy), $signed(exp_sxy));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_restart();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
